// File: rtl/pol_pkg.sv
// Shared pool-side constants: default scheduler parameters and owner-index width helper.
package pol_pkg;

  localparam int POL_POOL_CORE      = 6;
  localparam int POL_POOL_COMP_CORE = 64;
  localparam int POL_IDX_WIDTH      = 10;
  localparam int POL_ACT_WIDTH      = 8;
  localparam int POL_OUTSTD_DEPTH   = 4;

  // Owner index must be at least one bit wide even for a single-core pool.
  function automatic int own_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int POL_OWN_W = own_width(POL_POOL_CORE);

endpackage

// File: rtl/mif_sched_if.sv
// Pool/GLB handshake bundle seen by mif_sched; slave = scheduler side, master = cores plus GLB.
interface mif_sched_if
  import pol_pkg::*;
#(
  parameter int POOL_CORE      = POL_POOL_CORE,
  parameter int POOL_COMP_CORE = POL_POOL_COMP_CORE,
  parameter int IDX_WIDTH      = POL_IDX_WIDTH,
  parameter int ACT_WIDTH      = POL_ACT_WIDTH
);

  logic [POOL_CORE-1:0]                POLMIF_AddrVld;
  logic [IDX_WIDTH*POOL_CORE-1:0]      POLMIF_Addr;
  logic [POOL_CORE-1:0]                MIFPOL_AddrRdy;
  logic                                MIFGLB_AddrVld;
  logic [IDX_WIDTH-1:0]                MIFGLB_Addr;
  logic                                GLBMIF_AddrRdy;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBMIF_Ofm;
  logic                                GLBMIF_OfmVld;
  logic                                MIFGLB_OfmRdy;
  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Ofm;
  logic [POOL_CORE-1:0]                POLMIF_OfmRdy;
  logic [POOL_CORE-1:0]                MIFPOL_OfmVld;
  logic                                MIF_Idle;

  modport slave (
    input  POLMIF_AddrVld, POLMIF_Addr, GLBMIF_AddrRdy, GLBMIF_Ofm, GLBMIF_OfmVld, POLMIF_OfmRdy,
    output MIFPOL_AddrRdy, MIFGLB_AddrVld, MIFGLB_Addr, MIFGLB_OfmRdy, MIFPOL_Ofm, MIFPOL_OfmVld,
           MIF_Idle
  );

  modport master (
    output POLMIF_AddrVld, POLMIF_Addr, GLBMIF_AddrRdy, GLBMIF_Ofm, GLBMIF_OfmVld, POLMIF_OfmRdy,
    input  MIFPOL_AddrRdy, MIFGLB_AddrVld, MIFGLB_Addr, MIFGLB_OfmRdy, MIFPOL_Ofm, MIFPOL_OfmVld,
           MIF_Idle
  );

endinterface

// File: rtl/mif_id_fifo.sv
// Owner-index FIFO tracking outstanding GLB reads in issue order; 0-cycle head, 1-cycle push-to-head.
// Push while full is dropped unless a pop frees the slot in the same cycle; DEPTH is a power of two.
module mif_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign pop_ok  = pop & (count_q != '0);
  assign push_ok = push & ((count_q != (PW+1)'(DEPTH)) | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mif_sched.sv
// Round-robin GLB read scheduler for POOL_CORE cores; request-to-GLB valid 1 cycle, returns routed in order.
// Stalls grants when OUTSTD_DEPTH reads are in flight or held; MIF_SCHED_PERF_CNT_EN adds issue/stall counters.
module mif_sched
  import pol_pkg::*;
#(
  parameter int POOL_CORE      = POL_POOL_CORE,
  parameter int POOL_COMP_CORE = POL_POOL_COMP_CORE,
  parameter int IDX_WIDTH      = POL_IDX_WIDTH,
  parameter int ACT_WIDTH      = POL_ACT_WIDTH,
  parameter int OUTSTD_DEPTH   = POL_OUTSTD_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  mif_sched_if.slave  bus
`ifdef MIF_SCHED_PERF_CNT_EN
  ,
  output logic [31:0] MIF_IssueCnt,
  output logic [31:0] MIF_StallCnt
`endif
);

  localparam int OWN_W = own_width(POOL_CORE);
  localparam int CW    = $clog2(OUTSTD_DEPTH) + 1;

  logic [OWN_W-1:0]     ptr_q, ptr_d;
  logic                 reg_vld_q, reg_vld_d;
  logic [IDX_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [OWN_W-1:0]     reg_own_q, reg_own_d;

  logic                 grant_found;
  logic [OWN_W-1:0]     grant_idx;
  logic [OWN_W-1:0]     arb_idx;
  int                   arb_k;
  logic [IDX_WIDTH-1:0] req_addr;

  logic                 glb_hs;
  logic                 load;
  logic                 ret_hs;
  logic                 fifo_ne;
  logic                 ofm_rdy;
  logic [CW:0]          occ;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OWN_W-1:0]     fifo_head;
  logic [CW-1:0]        fifo_count;

  // Scan from ptr upward, wrapping, and take the first requesting core.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = '0;
    arb_k       = 0;
    for (int i = 0; i < POOL_CORE; i++) begin
      arb_k = int'(ptr_q) + i;
      if (arb_k >= POOL_CORE) begin
        arb_k = arb_k - POOL_CORE;
      end
      arb_idx = OWN_W'(arb_k);
      if (!grant_found && bus.POLMIF_AddrVld[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = arb_idx;
      end
    end
  end

  always_comb begin
    req_addr = '0;
    for (int i = 0; i < POOL_CORE; i++) begin
      if (grant_idx == OWN_W'(i)) begin
        req_addr = bus.POLMIF_Addr[i*IDX_WIDTH +: IDX_WIDTH];
      end
    end
  end

  // The held request counts against the outstanding budget before it is issued.
  assign occ    = (CW+1)'(fifo_count) + (CW+1)'(reg_vld_q);
  assign glb_hs = reg_vld_q & bus.GLBMIF_AddrRdy & ~rst;
  assign load   = grant_found & (~reg_vld_q | glb_hs) & ~fifo_full
                & (occ < (CW+1)'(OUTSTD_DEPTH)) & ~rst;

  always_comb begin
    ptr_d      = ptr_q;
    reg_vld_d  = reg_vld_q & ~glb_hs;
    reg_addr_d = reg_addr_q;
    reg_own_d  = reg_own_q;
    if (load) begin
      ptr_d      = (grant_idx == OWN_W'(POOL_CORE - 1)) ? '0 : grant_idx + 1'b1;
      reg_vld_d  = 1'b1;
      reg_addr_d = req_addr;
      reg_own_d  = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      reg_vld_q  <= 1'b0;
      reg_addr_q <= '0;
      reg_own_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      reg_vld_q  <= reg_vld_d;
      reg_addr_q <= reg_addr_d;
      reg_own_q  <= reg_own_d;
    end
  end

  mif_id_fifo #(
    .DEPTH (OUTSTD_DEPTH),
    .W     (OWN_W)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (glb_hs),
    .push_dat (reg_own_q),
    .pop      (ret_hs),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  // Return data with nothing outstanding is left unacknowledged and unrouted.
  assign fifo_ne = ~fifo_empty & ~rst;
  assign ofm_rdy = fifo_ne & bus.POLMIF_OfmRdy[fifo_head];
  assign ret_hs  = bus.GLBMIF_OfmVld & ofm_rdy;

  assign bus.MIFPOL_AddrRdy = load ? (POOL_CORE'(1) << grant_idx) : '0;
  assign bus.MIFGLB_AddrVld = reg_vld_q & ~rst;
  assign bus.MIFGLB_Addr    = rst ? '0 : reg_addr_q;
  assign bus.MIFGLB_OfmRdy  = ofm_rdy;
  assign bus.MIFPOL_Ofm     = bus.GLBMIF_Ofm;
  assign bus.MIFPOL_OfmVld  = (fifo_ne & bus.GLBMIF_OfmVld) ? (POOL_CORE'(1) << fifo_head) : '0;
  assign bus.MIF_Idle       = rst | (~reg_vld_q & fifo_empty);

`ifdef MIF_SCHED_PERF_CNT_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + {31'd0, glb_hs};
    stall_cnt_d = stall_cnt_q + {31'd0, (|bus.POLMIF_AddrVld) & ~load};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MIF_IssueCnt = issue_cnt_q;
  assign MIF_StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mif_sched.sv
// Bench for mif_sched: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mif_sched;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;

  mif_sched_if bus ();

`ifdef MIF_SCHED_PERF_CNT_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  mif_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MIF_SCHED_PERF_CNT_EN
    ,
    .MIF_IssueCnt (issue_cnt),
    .MIF_StallCnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: held request, in-order queue of owners in flight, GLB return schedule.
  bit          m_hvld;
  logic [9:0]  m_haddr;
  int          m_hown;
  int          m_ptr;
  int          m_q[$];
  int          ret_t[$];
  int unsigned m_issue;
  int unsigned m_stall;

  logic [5:0]  e_addr_rdy;
  logic [5:0]  e_ofm_vld;
  logic        e_glb_vld;
  logic [9:0]  e_glb_addr;
  logic        e_ofm_rdy;
  logic        e_idle;
  bit          e_load;
  bit          e_hs;
  bit          e_stall_inc;
  int          e_g;

  task automatic model_eval();
    int occ;
    e_g = -1;
    for (int i = 0; i < 6; i++) begin
      int k;
      k = (m_ptr + i) % 6;
      if (e_g < 0 && bus.POLMIF_AddrVld[k]) e_g = k;
    end
    e_hs        = !rst && m_hvld && bus.GLBMIF_AddrRdy;
    occ         = m_q.size() + int'(m_hvld);
    e_load      = !rst && (e_g >= 0) && (!m_hvld || e_hs) && (occ < 4);
    e_addr_rdy  = e_load ? 6'(1 << e_g) : 6'd0;
    e_glb_vld   = !rst && m_hvld;
    e_glb_addr  = rst ? 10'd0 : m_haddr;
    e_ofm_rdy   = !rst && (m_q.size() > 0) && bus.POLMIF_OfmRdy[m_q[0]];
    e_ofm_vld   = (!rst && (m_q.size() > 0) && bus.GLBMIF_OfmVld) ? 6'(1 << m_q[0]) : 6'd0;
    e_idle      = rst || (!m_hvld && m_q.size() == 0);
    e_stall_inc = !rst && (|bus.POLMIF_AddrVld) && !e_load;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_hvld = 0; m_haddr = '0; m_hown = 0; m_ptr = 0;
      m_q.delete(); ret_t.delete();
      m_issue = 0; m_stall = 0;
    end else begin
      if (bus.GLBMIF_OfmVld && e_ofm_rdy) begin
        void'(m_q.pop_front());
        if (ret_t.size() > 0) void'(ret_t.pop_front());
      end
      if (e_hs) begin
        m_q.push_back(m_hown);
        ret_t.push_back(cyc + 2);
        m_issue++;
      end
      if (e_stall_inc) m_stall++;
      if (e_load) begin
        m_hvld  = 1;
        m_haddr = bus.POLMIF_Addr[e_g*10 +: 10];
        m_hown  = e_g;
        m_ptr   = (e_g + 1) % 6;
      end else if (e_hs) begin
        m_hvld = 0;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    model_commit();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_data();
    bus.POLMIF_Addr = 60'({$urandom(), $urandom()});
    for (int w = 0; w < 16; w++) bus.GLBMIF_Ofm[w*32 +: 32] = $urandom();
  endtask

  task automatic idle_inputs();
    bus.POLMIF_AddrVld = '0;
    bus.GLBMIF_AddrRdy = 1'b1;
    bus.GLBMIF_OfmVld  = 1'b0;
    bus.POLMIF_OfmRdy  = 6'h3f;
    rand_data();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.POLMIF_AddrVld = 6'($urandom());
      bus.GLBMIF_AddrRdy = 1'b1;
      bus.GLBMIF_OfmVld  = 1'b1;
      bus.POLMIF_OfmRdy  = 6'h3f;
      rand_data();
      #1;
      checks++; if (bus.MIFPOL_AddrRdy !== 6'd0) begin errors++; $display("FAIL reset_addr_rdy got=%b exp=0", bus.MIFPOL_AddrRdy); end
      checks++; if (bus.MIFGLB_AddrVld !== 1'b0) begin errors++; $display("FAIL reset_glb_vld got=%b exp=0", bus.MIFGLB_AddrVld); end
      checks++; if (bus.MIFGLB_Addr !== 10'd0) begin errors++; $display("FAIL reset_glb_addr got=%h exp=0", bus.MIFGLB_Addr); end
      checks++; if (bus.MIFGLB_OfmRdy !== 1'b0) begin errors++; $display("FAIL reset_ofm_rdy got=%b exp=0", bus.MIFGLB_OfmRdy); end
      checks++; if (bus.MIFPOL_OfmVld !== 6'd0) begin errors++; $display("FAIL reset_ofm_vld got=%b exp=0", bus.MIFPOL_OfmVld); end
      checks++; if (bus.MIF_Idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", bus.MIF_Idle); end
`ifdef MIF_SCHED_PERF_CNT_EN
      if (c > 0) begin
        checks++; if (issue_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", issue_cnt, stall_cnt); end
      end
`endif
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int gq[$];
    int exp_order[7];
    exp_order = '{0, 1, 2, 3, 4, 5, 0};
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.POLMIF_AddrVld = 6'h3f;
      bus.GLBMIF_AddrRdy = 1'b1;
      bus.POLMIF_OfmRdy  = 6'h3f;
      rand_data();
      bus.GLBMIF_OfmVld  = (ret_t.size() > 0) && (ret_t[0] <= cyc);
      #1;
      model_eval();
      checks++; if (bus.MIFPOL_AddrRdy !== e_addr_rdy) begin errors++; $display("FAIL rr_addr_rdy cyc=%0d got=%b exp=%b", c, bus.MIFPOL_AddrRdy, e_addr_rdy); end
      checks++; if (bus.MIFPOL_OfmVld !== e_ofm_vld) begin errors++; $display("FAIL rr_ofm_vld cyc=%0d got=%b exp=%b", c, bus.MIFPOL_OfmVld, e_ofm_vld); end
      checks++; if (bus.MIFPOL_Ofm !== bus.GLBMIF_Ofm) begin errors++; $display("FAIL rr_ofm_data cyc=%0d got=%h exp=%h", c, bus.MIFPOL_Ofm[31:0], bus.GLBMIF_Ofm[31:0]); end
      if (e_glb_vld) begin
        checks++; if (bus.MIFGLB_Addr !== e_glb_addr) begin errors++; $display("FAIL rr_glb_addr cyc=%0d got=%h exp=%h", c, bus.MIFGLB_Addr, e_glb_addr); end
      end
      for (int i = 0; i < 6; i++) if (bus.MIFPOL_AddrRdy[i]) gq.push_back(i);
      tick();
    end
    checks++; if (gq.size() < 7) begin errors++; $display("FAIL rr_grant_count got=%0d exp>=7", gq.size()); end
    for (int i = 0; i < 7 && i < gq.size(); i++) begin
      checks++; if (gq[i] !== exp_order[i]) begin errors++; $display("FAIL rr_grant_order idx=%0d got=%0d exp=%0d", i, gq[i], exp_order[i]); end
    end
  endtask

  task automatic test_single_core3();
    do_reset();
    bus.POLMIF_AddrVld = 6'b001000;
    bus.GLBMIF_AddrRdy = 1'b1;
    rand_data();
    bus.POLMIF_Addr[30 +: 10] = 10'h155;
    #1;
    checks++; if (bus.MIFPOL_AddrRdy !== 6'b001000) begin errors++; $display("FAIL c3_addr_rdy got=%b exp=001000", bus.MIFPOL_AddrRdy); end
    checks++; if (bus.MIFGLB_AddrVld !== 1'b0) begin errors++; $display("FAIL c3_glb_vld_early got=%b exp=0", bus.MIFGLB_AddrVld); end
    tick();
    bus.POLMIF_AddrVld = 6'd0;
    #1;
    checks++; if (bus.MIFGLB_AddrVld !== 1'b1) begin errors++; $display("FAIL c3_glb_vld got=%b exp=1", bus.MIFGLB_AddrVld); end
    checks++; if (bus.MIFGLB_Addr !== 10'h155) begin errors++; $display("FAIL c3_glb_addr got=%h exp=155", bus.MIFGLB_Addr); end
    tick();
  endtask

  task automatic test_addr_hold();
    logic [9:0] a0;
    do_reset();
    rand_data();
    a0 = bus.POLMIF_Addr[9:0];
    bus.POLMIF_AddrVld = 6'b000011;
    bus.GLBMIF_AddrRdy = 1'b0;
    #1;
    checks++; if (bus.MIFPOL_AddrRdy !== 6'b000001) begin errors++; $display("FAIL hold_first_grant got=%b exp=000001", bus.MIFPOL_AddrRdy); end
    tick();
    bus.GLBMIF_OfmVld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.POLMIF_Addr[19:0] = 20'($urandom());
      #1;
      checks++; if (bus.MIFGLB_AddrVld !== 1'b1 || bus.MIFGLB_Addr !== a0) begin errors++; $display("FAIL hold_addr cyc=%0d got=%b/%h exp=1/%h", c, bus.MIFGLB_AddrVld, bus.MIFGLB_Addr, a0); end
      checks++; if (bus.MIFPOL_AddrRdy !== 6'd0) begin errors++; $display("FAIL hold_no_grant cyc=%0d got=%b exp=0", c, bus.MIFPOL_AddrRdy); end
      checks++; if (bus.MIFGLB_OfmRdy !== 1'b0 || bus.MIFPOL_OfmVld !== 6'd0) begin errors++; $display("FAIL hold_fifo_empty cyc=%0d got=%b/%b exp=0/0", c, bus.MIFGLB_OfmRdy, bus.MIFPOL_OfmVld); end
      tick();
    end
    bus.GLBMIF_OfmVld  = 1'b0;
    bus.GLBMIF_AddrRdy = 1'b1;
    #1;
    checks++; if (bus.MIFPOL_AddrRdy !== 6'b000010) begin errors++; $display("FAIL hold_release_grant got=%b exp=000010", bus.MIFPOL_AddrRdy); end
    tick();
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    bus.POLMIF_AddrVld = 6'h3f;
    bus.GLBMIF_AddrRdy = 1'b1;
    bus.GLBMIF_OfmVld  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 4) begin
        checks++; if (bus.MIFPOL_AddrRdy !== 6'(1 << c)) begin errors++; $display("FAIL lim_grant cyc=%0d got=%b exp=%b", c, bus.MIFPOL_AddrRdy, 6'(1 << c)); end
      end else begin
        checks++; if (bus.MIFPOL_AddrRdy !== 6'd0) begin errors++; $display("FAIL lim_no_grant cyc=%0d got=%b exp=0", c, bus.MIFPOL_AddrRdy); end
      end
      if (c >= 5) begin
        checks++; if (bus.MIFGLB_AddrVld !== 1'b0) begin errors++; $display("FAIL lim_glb_vld cyc=%0d got=%b exp=0", c, bus.MIFGLB_AddrVld); end
      end
`ifdef MIF_SCHED_PERF_CNT_EN
      checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL lim_stall_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
`endif
      tick();
    end
    bus.GLBMIF_OfmVld = 1'b1;
    #1;
    checks++; if (bus.MIFPOL_OfmVld !== 6'b000001 || bus.MIFGLB_OfmRdy !== 1'b1) begin errors++; $display("FAIL lim_return got=%b/%b exp=000001/1", bus.MIFPOL_OfmVld, bus.MIFGLB_OfmRdy); end
    checks++; if (bus.MIFPOL_AddrRdy !== 6'd0) begin errors++; $display("FAIL lim_return_no_grant got=%b exp=0", bus.MIFPOL_AddrRdy); end
`ifdef MIF_SCHED_PERF_CNT_EN
    checks++; if (issue_cnt !== 32'd4) begin errors++; $display("FAIL lim_issue_cnt got=%0d exp=4", issue_cnt); end
`endif
    tick();
    bus.GLBMIF_OfmVld = 1'b0;
    #1;
    checks++; if (bus.MIFPOL_AddrRdy !== 6'b010000) begin errors++; $display("FAIL lim_reissue got=%b exp=010000", bus.MIFPOL_AddrRdy); end
    tick();
  endtask

  task automatic test_head_stall();
    do_reset();
    bus.POLMIF_AddrVld = 6'b000100;
    tick();
    bus.POLMIF_AddrVld = 6'd0;
    tick();
    bus.GLBMIF_OfmVld = 1'b1;
    bus.POLMIF_OfmRdy = 6'b111011;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.MIFGLB_OfmRdy !== 1'b0) begin errors++; $display("FAIL hs_ofm_rdy cyc=%0d got=%b exp=0", c, bus.MIFGLB_OfmRdy); end
      checks++; if (bus.MIFPOL_OfmVld !== 6'b000100) begin errors++; $display("FAIL hs_ofm_vld cyc=%0d got=%b exp=000100", c, bus.MIFPOL_OfmVld); end
      tick();
    end
    bus.POLMIF_OfmRdy = 6'h3f;
    #1;
    checks++; if (bus.MIFGLB_OfmRdy !== 1'b1 || bus.MIFPOL_OfmVld !== 6'b000100) begin errors++; $display("FAIL hs_accept got=%b/%b exp=1/000100", bus.MIFGLB_OfmRdy, bus.MIFPOL_OfmVld); end
    tick();
    bus.GLBMIF_OfmVld = 1'b0;
    #1;
    checks++; if (bus.MIF_Idle !== 1'b1) begin errors++; $display("FAIL hs_idle got=%b exp=1", bus.MIF_Idle); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.POLMIF_AddrVld = 6'b000111;
    for (int c = 0; c < 3; c++) tick();
    bus.POLMIF_AddrVld = 6'd0;
    for (int c = 0; c < 3; c++) tick();
    #1;
    checks++; if (bus.MIF_Idle !== 1'b0 || m_q.size() != 3) begin errors++; $display("FAIL mr_busy got=%b exp=0 (model outstanding %0d)", bus.MIF_Idle, m_q.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.GLBMIF_OfmVld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.MIF_Idle !== 1'b1) begin errors++; $display("FAIL mr_idle cyc=%0d got=%b exp=1", c, bus.MIF_Idle); end
      checks++; if (bus.MIFPOL_OfmVld !== 6'd0 || bus.MIFGLB_OfmRdy !== 1'b0) begin errors++; $display("FAIL mr_stray cyc=%0d got=%b/%b exp=0/0", c, bus.MIFPOL_OfmVld, bus.MIFGLB_OfmRdy); end
      tick();
    end
    bus.GLBMIF_OfmVld = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.POLMIF_AddrVld = 6'($urandom());
      bus.GLBMIF_AddrRdy = ($urandom_range(0, 3) != 0);
      bus.POLMIF_OfmRdy  = 6'($urandom()) | 6'($urandom());
      rand_data();
      if (ret_t.size() > 0 && ret_t[0] <= cyc) bus.GLBMIF_OfmVld = ($urandom_range(0, 3) != 0);
      else                                     bus.GLBMIF_OfmVld = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      checks++; if (bus.MIFPOL_AddrRdy !== e_addr_rdy) begin errors++; $display("FAIL rnd_addr_rdy cyc=%0d got=%b exp=%b", c, bus.MIFPOL_AddrRdy, e_addr_rdy); end
      checks++; if (bus.MIFGLB_AddrVld !== e_glb_vld) begin errors++; $display("FAIL rnd_glb_vld cyc=%0d got=%b exp=%b", c, bus.MIFGLB_AddrVld, e_glb_vld); end
      if (e_glb_vld || rst) begin
        checks++; if (bus.MIFGLB_Addr !== e_glb_addr) begin errors++; $display("FAIL rnd_glb_addr cyc=%0d got=%h exp=%h", c, bus.MIFGLB_Addr, e_glb_addr); end
      end
      checks++; if (bus.MIFGLB_OfmRdy !== e_ofm_rdy) begin errors++; $display("FAIL rnd_ofm_rdy cyc=%0d got=%b exp=%b", c, bus.MIFGLB_OfmRdy, e_ofm_rdy); end
      checks++; if (bus.MIFPOL_OfmVld !== e_ofm_vld) begin errors++; $display("FAIL rnd_ofm_vld cyc=%0d got=%b exp=%b", c, bus.MIFPOL_OfmVld, e_ofm_vld); end
      checks++; if (bus.MIF_Idle !== e_idle) begin errors++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", c, bus.MIF_Idle, e_idle); end
`ifdef MIF_SCHED_PERF_CNT_EN
      checks++; if (issue_cnt !== m_issue || stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, issue_cnt, stall_cnt, m_issue, m_stall); end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b1;
    m_hvld = 0; m_haddr = '0; m_hown = 0; m_ptr = 0;
    m_issue = 0; m_stall = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single_core3();
    test_addr_hold();
    test_outstanding_limit();
    test_head_stall();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
